// File: rtl/mc_block_sequencer_if.sv
// rtl/mc_block_sequencer_if.sv - command, reference-request and result signals of the MC block sequencer
interface mc_block_sequencer_if #(
  parameter int COORD_W = 12,
  parameter int SIZE_W  = 5,
  parameter int MV_W    = 16,
  parameter int FRAC_W  = 8
);
  logic                      cmd_valid;
  logic                      cmd_ready;
  logic [COORD_W-1:0]        cmd_x;
  logic [COORD_W-1:0]        cmd_y;
  logic [SIZE_W-1:0]         cmd_w_m1;
  logic [SIZE_W-1:0]         cmd_h_m1;
  logic signed [MV_W-1:0]    cmd_mv_x;
  logic signed [MV_W-1:0]    cmd_mv_y;

  logic                      req_valid;
  logic                      req_ready;
  logic [COORD_W-1:0]        req_x;
  logic [COORD_W-1:0]        req_y;
  logic [FRAC_W-1:0]         req_frac_x;
  logic [FRAC_W-1:0]         req_frac_y;
  logic                      req_last;

  logic                      res_valid;

  // Command source, fetch unit and interpolator side
  modport master (
    output cmd_valid, cmd_x, cmd_y, cmd_w_m1, cmd_h_m1, cmd_mv_x, cmd_mv_y,
    input  cmd_ready,
    input  req_valid, req_x, req_y, req_frac_x, req_frac_y, req_last,
    output req_ready,
    output res_valid
  );

  // Sequencer side
  modport slave (
    input  cmd_valid, cmd_x, cmd_y, cmd_w_m1, cmd_h_m1, cmd_mv_x, cmd_mv_y,
    output cmd_ready,
    output req_valid, req_x, req_y, req_frac_x, req_frac_y, req_last,
    input  req_ready,
    input  res_valid
  );
endinterface

// File: rtl/mc_block_sequencer.sv
// rtl/mc_block_sequencer.sv - raster-order bilinear MC request sequencer with credit tracking (optional MC_CLAMP_EN edge clamp)
module mc_block_sequencer #(
  parameter int COORD_W      = 12,
  parameter int SIZE_W       = 5,
  parameter int MV_W         = 16,
  parameter int MV_FRAC      = 2,
  parameter int FRAC_W       = 8,
  parameter int MAX_INFLIGHT = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [COORD_W-1:0] i_pic_w_m1,
  input  logic [COORD_W-1:0] i_pic_h_m1,
  mc_block_sequencer_if.slave io_mc,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_err_credit
);
  localparam int IW = $clog2(MAX_INFLIGHT) + 1;
  localparam int XW = COORD_W + 2;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;

  logic [COORD_W-1:0]      r_x;
  logic [COORD_W-1:0]      r_y;
  logic [SIZE_W-1:0]       r_w_m1;
  logic [SIZE_W-1:0]       r_h_m1;
  logic signed [MV_W-1:0]  r_mv_x;
  logic signed [MV_W-1:0]  r_mv_y;
  logic [SIZE_W-1:0]       r_col;
  logic [SIZE_W-1:0]       r_row;
  logic [IW-1:0]           r_inflight;
  logic                    r_err;

  logic                    w_cmd_fire;
  logic                    w_can_issue;
  logic                    w_req_fire;
  logic                    w_res_take;
  logic                    w_row_end;
  logic                    w_last;
  logic [IW-1:0]           w_inflight_nxt;
  logic signed [MV_W-1:0]  w_mv_sh_x;
  logic signed [MV_W-1:0]  w_mv_sh_y;
  logic [XW-1:0]           w_ix;
  logic [XW-1:0]           w_iy;
  logic [COORD_W-1:0]      w_req_x;
  logic [COORD_W-1:0]      w_req_y;
  logic                    w_unused;

  assign w_cmd_fire  = (r_state == S_IDLE) && io_mc.cmd_valid;
  assign w_can_issue = (r_inflight < IW'(MAX_INFLIGHT));
  // Derived from state rather than req_valid so the FSM block has no combinational self-dependency
  assign w_req_fire  = (r_state == S_ISSUE) && w_can_issue && io_mc.req_ready;
  // A result with nothing outstanding is dropped and only flagged
  assign w_res_take  = io_mc.res_valid && (r_inflight != '0);
  assign w_row_end   = (r_col == r_w_m1);
  assign w_last      = w_row_end && (r_row == r_h_m1);
  assign w_inflight_nxt = r_inflight + IW'(w_req_fire) - IW'(w_res_take);

  // Integer MV part (floor toward -inf); the sum is done modulo 2^XW so the top bit acts as sign
  assign w_mv_sh_x = r_mv_x >>> MV_FRAC;
  assign w_mv_sh_y = r_mv_y >>> MV_FRAC;
  assign w_ix = {2'b00, r_x} + {{(XW-SIZE_W){1'b0}}, r_col} + w_mv_sh_x[XW-1:0];
  assign w_iy = {2'b00, r_y} + {{(XW-SIZE_W){1'b0}}, r_row} + w_mv_sh_y[XW-1:0];

`ifdef MC_CLAMP_EN
  assign w_req_x = w_ix[XW-1] ? '0 :
                   (w_ix > {2'b00, i_pic_w_m1}) ? i_pic_w_m1 : w_ix[COORD_W-1:0];
  assign w_req_y = w_iy[XW-1] ? '0 :
                   (w_iy > {2'b00, i_pic_h_m1}) ? i_pic_h_m1 : w_iy[COORD_W-1:0];
  assign w_unused = ^{w_mv_sh_x[MV_W-1:XW], w_mv_sh_y[MV_W-1:XW]};
`else
  assign w_req_x = w_ix[COORD_W-1:0];
  assign w_req_y = w_iy[COORD_W-1:0];
  assign w_unused = ^{w_mv_sh_x[MV_W-1:XW], w_mv_sh_y[MV_W-1:XW],
                      w_ix[XW-1:COORD_W], w_iy[XW-1:COORD_W], i_pic_w_m1, i_pic_h_m1};
`endif

  assign io_mc.req_x      = w_req_x;
  assign io_mc.req_y      = w_req_y;
  assign io_mc.req_last   = w_last;
  assign io_mc.req_frac_x = FRAC_W'(r_mv_x[MV_FRAC-1:0]) << (FRAC_W - MV_FRAC);
  assign io_mc.req_frac_y = FRAC_W'(r_mv_y[MV_FRAC-1:0]) << (FRAC_W - MV_FRAC);
  assign o_err_credit     = r_err;

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // FSM next-state and control outputs
  always_comb begin
    w_state_nxt     = r_state;
    io_mc.cmd_ready = 1'b0;
    io_mc.req_valid = 1'b0;
    o_busy          = 1'b1;
    o_done          = 1'b0;
    case (r_state)
      S_IDLE: begin
        io_mc.cmd_ready = 1'b1;
        o_busy          = 1'b0;
        if (io_mc.cmd_valid) w_state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        io_mc.req_valid = w_can_issue;
        if (w_req_fire && w_last) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        // Look at the next credit count so done follows the final result by one cycle
        if (w_inflight_nxt == '0) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        o_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Command latch, raster counters, credit counter and sticky credit error
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_x        <= '0;
      r_y        <= '0;
      r_w_m1     <= '0;
      r_h_m1     <= '0;
      r_mv_x     <= '0;
      r_mv_y     <= '0;
      r_col      <= '0;
      r_row      <= '0;
      r_inflight <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_cmd_fire) begin
        r_x    <= io_mc.cmd_x;
        r_y    <= io_mc.cmd_y;
        r_w_m1 <= io_mc.cmd_w_m1;
        r_h_m1 <= io_mc.cmd_h_m1;
        r_mv_x <= io_mc.cmd_mv_x;
        r_mv_y <= io_mc.cmd_mv_y;
        r_col  <= '0;
        r_row  <= '0;
      end else if (w_req_fire) begin
        if (w_last) begin
          r_col <= '0;
          r_row <= '0;
        end else if (w_row_end) begin
          r_col <= '0;
          r_row <= r_row + SIZE_W'(1);
        end else begin
          r_col <= r_col + SIZE_W'(1);
        end
      end
      r_inflight <= w_inflight_nxt;
      if (io_mc.res_valid && (r_inflight == '0)) r_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mc_block_sequencer.sv
// tb/tb_mc_block_sequencer.sv - directed self-checking bench for mc_block_sequencer
module tb_mc_block_sequencer;
  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] pic_w_m1;
  logic [11:0] pic_h_m1;
  logic        busy;
  logic        done;
  logic        err;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mc_block_sequencer_if #(.COORD_W(12), .SIZE_W(5), .MV_W(16), .FRAC_W(8)) mc();

  mc_block_sequencer #(
    .COORD_W(12), .SIZE_W(5), .MV_W(16), .MV_FRAC(2), .FRAC_W(8), .MAX_INFLIGHT(8)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_pic_w_m1(pic_w_m1),
    .i_pic_h_m1(pic_h_m1),
    .io_mc(mc),
    .o_busy(busy),
    .o_done(done),
    .o_err_credit(err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input int x, input int y, input int wm1, input int hm1,
                          input int mvx, input int mvy);
    mc.cmd_x     = 12'(x);
    mc.cmd_y     = 12'(y);
    mc.cmd_w_m1  = 5'(wm1);
    mc.cmd_h_m1  = 5'(hm1);
    mc.cmd_mv_x  = 16'(mvx);
    mc.cmd_mv_y  = 16'(mvy);
    mc.cmd_valid = 1'b1;
    step();
    mc.cmd_valid = 1'b0;
  endtask

  // Returns n results one per cycle; done must appear exactly one cycle after the last
  task automatic finish_block(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      mc.res_valid = 1'b1;
      chk({tag, "_done_early"}, 32'(done), 0);
      step();
    end
    mc.res_valid = 1'b0;
    chk({tag, "_done"}, 32'(done), 1);
    chk({tag, "_busy_in_done"}, 32'(busy), 1);
    step();
    chk({tag, "_done_pulse"}, 32'(done), 0);
    chk({tag, "_busy_after"}, 32'(busy), 0);
    chk({tag, "_cmd_ready_after"}, 32'(mc.cmd_ready), 1);
  endtask

  initial begin : main
    int fires;
    int lastcnt;
    int lastidx;
    int k;
    bit got_done;
    bit pat [4];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};

    rst          = 1'b1;
    pic_w_m1     = 12'd63;
    pic_h_m1     = 12'd63;
    mc.cmd_valid = 1'b0;
    mc.cmd_x     = '0;
    mc.cmd_y     = '0;
    mc.cmd_w_m1  = '0;
    mc.cmd_h_m1  = '0;
    mc.cmd_mv_x  = '0;
    mc.cmd_mv_y  = '0;
    mc.req_ready = 1'b1;
    mc.res_valid = 1'b0;
    step();
    step();
    chk("rst_cmd_ready", 32'(mc.cmd_ready), 1);
    chk("rst_req_valid", 32'(mc.req_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    rst = 1'b0;
    step();

    // 4x2 block at (16,8), mv (+5,-3) quarter-pel
    send_cmd(16, 8, 3, 1, 5, -3);
    chk("t1_busy", 32'(busy), 1);
    chk("t1_cmd_ready", 32'(mc.cmd_ready), 0);
    for (int i = 0; i < 8; i++) begin
      chk("t1_req_valid", 32'(mc.req_valid), 1);
      chk("t1_req_x", 32'(mc.req_x), 17 + i % 4);
      chk("t1_req_y", 32'(mc.req_y), 7 + i / 4);
      chk("t1_frac_x", 32'(mc.req_frac_x), 32'h40);
      chk("t1_frac_y", 32'(mc.req_frac_y), 32'h40);
      chk("t1_req_last", 32'(mc.req_last), 32'(i == 7));
      step();
    end
    chk("t1_drain_req_valid", 32'(mc.req_valid), 0);
    finish_block("t1", 8);

    // 4x4 block, no results: credits cap at 8 outstanding
    send_cmd(0, 0, 3, 3, 0, 0);
    fires = 0;
    for (int i = 0; i < 12; i++) begin
      if (mc.req_valid && mc.req_ready) fires++;
      step();
    end
    chk("t2_fires_cap", 32'(fires), 8);
    chk("t2_stalled", 32'(mc.req_valid), 0);
    mc.res_valid = 1'b1;
    step();
    mc.res_valid = 1'b0;
    k = 0;
    for (int i = 0; i < 5; i++) begin
      if (mc.req_valid && mc.req_ready) k++;
      step();
    end
    chk("t2_one_more", 32'(k), 1);
    fires = fires + k;
    // Simultaneous handshake and result: credit count must hold at 7
    mc.res_valid = 1'b1;
    chk("t5_pre_stall", 32'(mc.req_valid), 0);
    step();
    chk("t5_valid_a", 32'(mc.req_valid), 1);
    if (mc.req_valid && mc.req_ready) fires++;
    step();
    chk("t5_simul_unchanged", 32'(mc.req_valid), 1);
    lastcnt  = 0;
    lastidx  = 0;
    got_done = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (done) begin
        got_done = 1'b1;
        break;
      end
      if (mc.req_valid && mc.req_ready) begin
        fires++;
        if (mc.req_last) begin
          lastcnt++;
          lastidx = fires;
        end
      end
      step();
    end
    mc.res_valid = 1'b0;
    chk("t2_done_seen", 32'(got_done), 1);
    chk("t2_total_fires", 32'(fires), 16);
    chk("t2_last_count", 32'(lastcnt), 1);
    chk("t2_last_index", 32'(lastidx), 16);
    chk("t2_err", 32'(err), 0);
    step();
    chk("t2_idle_busy", 32'(busy), 0);

    // 2x2 block at (100,200), mv (8,4); ready toggles 1,0,0,1
    send_cmd(100, 200, 1, 1, 8, 4);
    k = 0;
    for (int c = 0; c < 30 && k < 4; c++) begin
      mc.req_ready = pat[c % 4];
      chk("t3_req_valid", 32'(mc.req_valid), 1);
      chk("t3_req_x", 32'(mc.req_x), 102 + k % 2);
      chk("t3_req_y", 32'(mc.req_y), 201 + k / 2);
      chk("t3_req_last", 32'(mc.req_last), 32'(k == 3));
      chk("t3_frac_x", 32'(mc.req_frac_x), 0);
      if (mc.req_ready) k++;
      step();
    end
    mc.req_ready = 1'b1;
    chk("t3_all_issued", 32'(k), 4);
    chk("t3_drain_req_valid", 32'(mc.req_valid), 0);
    finish_block("t3", 4);

    // 2x2 block at (0,0), mv (-40,-40), 64x64 picture
    send_cmd(0, 0, 1, 1, -40, -40);
    for (int i = 0; i < 4; i++) begin
`ifdef MC_CLAMP_EN
      chk("t4_req_x", 32'(mc.req_x), 0);
      chk("t4_req_y", 32'(mc.req_y), 0);
`else
      chk("t4_req_x", 32'(mc.req_x), 32'hFF6 + i % 2);
      chk("t4_req_y", 32'(mc.req_y), 32'hFF6 + i / 2);
`endif
      chk("t4_frac_x", 32'(mc.req_frac_x), 0);
      step();
    end
    finish_block("t4", 4);

    // 1x1 block: single request flagged last
    send_cmd(3, 3, 0, 0, 0, 0);
    chk("t1x1_req_valid", 32'(mc.req_valid), 1);
    chk("t1x1_req_last", 32'(mc.req_last), 1);
    chk("t1x1_req_x", 32'(mc.req_x), 3);
    step();
    chk("t1x1_after", 32'(mc.req_valid), 0);
    finish_block("t1x1", 1);

    // Reset mid-ISSUE, then restart from column 0, row 0
    send_cmd(10, 20, 3, 3, 0, 0);
    step();
    step();
    step();
    chk("t6_mid_x", 32'(mc.req_x), 13);
    rst = 1'b1;
    step();
    chk("t6_rst_req_valid", 32'(mc.req_valid), 0);
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_cmd_ready", 32'(mc.cmd_ready), 1);
    rst = 1'b0;
    send_cmd(5, 6, 1, 0, 0, 0);
    chk("t6_restart_x", 32'(mc.req_x), 5);
    chk("t6_restart_y", 32'(mc.req_y), 6);
    chk("t6_restart_last", 32'(mc.req_last), 0);
    step();
    chk("t6_second_x", 32'(mc.req_x), 6);
    chk("t6_second_last", 32'(mc.req_last), 1);
    step();
    finish_block("t6", 2);

    // Stray result while idle sets the sticky credit error
    chk("t5_err_before", 32'(err), 0);
    mc.res_valid = 1'b1;
    step();
    mc.res_valid = 1'b0;
    chk("t5_err_set", 32'(err), 1);
    step();
    step();
    chk("t5_err_sticky", 32'(err), 1);
    chk("t5_idle_ready", 32'(mc.cmd_ready), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
